// File: rtl/gpio_serial_loader_if.sv
// Configuration-write, transfer-request and serial-chain signals of the GPIO loader.
// The management side drives through master; the loader consumes through slave.
interface gpio_serial_loader_if #(
    parameter int CFG_BITS = 13
) ();
    logic                cfg_we;
    logic [5:0]          cfg_addr;
    logic [CFG_BITS-1:0] cfg_wdata;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                cfg_wr_err;
    logic                xfer_start;
    logic                busy;
    logic                done;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                serial_resetn;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, xfer_start,
        input  cfg_rdata, cfg_wr_err, busy, done,
               serial_clock, serial_data, serial_load, serial_resetn
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, xfer_start,
        output cfg_rdata, cfg_wr_err, busy, done,
               serial_clock, serial_data, serial_load, serial_resetn
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// Holds one config word per user pad and shifts them into the GPIO control chain
// (last pad first, MSB first), then pulses the chain load strobe.
module gpio_serial_loader #(
    parameter int                  NUM_PADS = 38,
    parameter int                  CFG_BITS = 13,
    parameter int                  CLK_DIV  = 2,
    parameter logic [CFG_BITS-1:0] CFG_RST  = 13'h0403
) (
    input  logic                 clock,
    input  logic                 resetb,
    gpio_serial_loader_if.slave  bus
);

    localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PAD_W-1:0]    pad_q, pad_d;
    logic [CFG_BITS-1:0] store_q [NUM_PADS];
    logic [CFG_BITS-1:0] store_d [NUM_PADS];
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_err_q, wr_err_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                sload_q, sload_d;

    logic                addr_ok;
    logic                wr_ok;
    logic                div_end;
    logic                cur_bit;
    logic [CFG_BITS-1:0] cur_word;

    assign addr_ok  = {1'b0, bus.cfg_addr} < 7'(NUM_PADS);
    assign wr_ok    = bus.cfg_we && (state_q == IDLE) && addr_ok;
    assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));
    assign cur_word = store_q[pad_q];
    assign cur_bit  = cur_word[BIT_W'(CFG_BITS - 1) - bit_q];

    always_comb begin
        store_d = store_q;
        if (wr_ok) begin
            store_d[bus.cfg_addr] = bus.cfg_wdata;
        end
    end

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        pad_d   = pad_q;
        case (state_q)
            IDLE: begin
                if (bus.xfer_start && rst_sync_q[1]) begin
                    state_d = SHIFT_LO;
                    div_d   = '0;
                    bit_d   = '0;
                    pad_d   = PAD_W'(NUM_PADS - 1);
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == BIT_W'(CFG_BITS - 1)) begin
                        bit_d = '0;
                        if (pad_q == '0) begin
                            state_d = LOAD;
                        end else begin
                            pad_d   = pad_q - 1'b1;
                            state_d = SHIFT_LO;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so every pin lags the
    // FSM by one cycle; the word is read from the store while in SHIFT_LO.
    always_comb begin
        busy_d   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
        done_d   = (state_q == DONE);
        sclk_d   = (state_q == SHIFT_HI);
        sload_d  = (state_q == LOAD);
        wr_err_d = bus.cfg_we && ((state_q != IDLE) || !addr_ok);
        sdata_d  = 1'b0;
        if (state_q == SHIFT_LO) begin
            sdata_d = cur_bit;
        end else if (state_q == SHIFT_HI) begin
            sdata_d = sdata_q;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            pad_q      <= '0;
            store_q    <= '{default: CFG_RST};
            rst_sync_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sload_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            pad_q      <= pad_d;
            store_q    <= store_d;
            rst_sync_q <= rst_sync_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_err_q   <= wr_err_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            sload_q    <= sload_d;
        end
    end

    assign bus.cfg_rdata     = addr_ok ? store_q[bus.cfg_addr] : '0;
    assign bus.cfg_wr_err    = wr_err_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.serial_clock  = sclk_q;
    assign bus.serial_data   = sdata_q;
    assign bus.serial_load   = sload_q;
    assign bus.serial_resetn = rst_sync_q[1];

endmodule
